accum_warp_looper_stencil_lanes: RTL

- Generalised stencil expansion stage of the accumulation warp looper.
- Takes one warp descriptor per handshake: config id, base linear address, block offsets, retire/islast flags, stencil enable.
- Emits a sequence of output beats. Each beat carries up to N_LANE stencil addresses (base + LUT entry), with a per-lane valid mask.
- Retire/islast are qualified onto the final beat only. Sits between the warp looper address stage and the downstream address/accumulate pipe.

---
 rtl/accum_warp_looper_stencil_lanes.sv | 139 +++++++++++++
 1 files changed

// File: rtl/accum_warp_looper_stencil_lanes.sv
// Stencil expansion stage: turns one warp descriptor into beats of up to N_LANE LUT-offset addresses.
// Optional STENCIL_SKIP_EN adds a per-LUT-entry skip mask that clears lane valid bits.
module accum_warp_looper_stencil_lanes #(
    parameter int N_CFG  = 4,
    parameter int ABW    = 16,
    parameter int WBW    = 8,
    parameter int VDIM   = 3,
    parameter int STSIZE = 8,
    parameter int N_LANE = 2,
    localparam int NCFG_BW = $clog2(N_CFG + 1),
    localparam int ST_BW   = $clog2(STSIZE + 1),
    localparam int LN_BW   = $clog2(N_LANE + 1)
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             src_rdy,
    output logic                             src_ack,
    input  logic [NCFG_BW-1:0]               i_id,
    input  logic [ABW-1:0]                   i_linear,
    input  logic [VDIM-1:0][WBW-1:0]         i_bofs,
    input  logic                             i_retire,
    input  logic                             i_islast,
    input  logic                             i_stencil,
    input  logic [N_CFG-1:0][ST_BW-1:0]      i_stencil_begs,
    input  logic [N_CFG-1:0][ST_BW-1:0]      i_stencil_ends,
    input  logic [STSIZE-1:0][ABW-1:0]       i_stencil_lut,
`ifdef STENCIL_SKIP_EN
    input  logic [STSIZE-1:0]                i_stencil_skip,
`endif
    output logic                             dst_rdy,
    input  logic                             dst_ack,
    output logic [NCFG_BW-1:0]               o_id,
    output logic [N_LANE-1:0][ABW-1:0]       o_linear,
    output logic [N_LANE-1:0]                o_lane_valid,
    output logic [LN_BW-1:0]                 o_nlane,
    output logic [VDIM-1:0][WBW-1:0]         o_bofs,
    output logic                             o_retire,
    output logic                             o_islast
);

    // Index width wide enough for sid + lane without wrapping.
    localparam int IW = ST_BW + LN_BW;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                     state;
    logic [NCFG_BW-1:0]         id_r;
    logic [ABW-1:0]             linear_r;
    logic [VDIM-1:0][WBW-1:0]   bofs_r;
    logic                       retire_r;
    logic                       islast_r;
    logic                       stencil_r;
    logic [ST_BW-1:0]           sid;

    logic [ST_BW-1:0]           beg_sel;
    logic [ST_BW-1:0]           end_sel;
    logic [N_LANE-1:0]          lane_v;
    logic [N_LANE-1:0][ABW-1:0] lane_addr;
    logic [LN_BW-1:0]           nlane;
    logic                       final_beat;
    logic                       busy;

    assign busy = (state == BUSY);

    // Config lookups are done as compare-muxes so an out-of-range id reads zero.
    always_comb begin
        beg_sel = '0;
        end_sel = '0;
        for (int c = 0; c < N_CFG; c++) begin
            if (i_id == NCFG_BW'(c)) beg_sel = i_stencil_begs[c];
            if (id_r == NCFG_BW'(c)) end_sel = i_stencil_ends[c];
        end
    end

    always_comb begin
        logic [IW-1:0]  idx;
        logic [ABW-1:0] ofs;
        logic           in_rng;
        logic           skip_hit;
        lane_v    = '0;
        lane_addr = '0;
        nlane     = '0;
        for (int k = 0; k < N_LANE; k++) begin
            idx      = IW'(sid) + IW'(k);
            in_rng   = stencil_r && (idx < IW'(end_sel));
            ofs      = '0;
            skip_hit = 1'b0;
            for (int j = 0; j < STSIZE; j++) begin
                if (idx == IW'(j)) begin
                    ofs = i_stencil_lut[j];
`ifdef STENCIL_SKIP_EN
                    skip_hit = i_stencil_skip[j];
`endif
                end
            end
            lane_addr[k] = in_rng ? linear_r + ofs : linear_r;
            lane_v[k]    = busy && (stencil_r ? (in_rng && !skip_hit) : (k == 0));
            nlane        = nlane + LN_BW'(lane_v[k]);
        end
        final_beat = !stencil_r || (IW'(sid) + IW'(N_LANE) >= IW'(end_sel));
    end

    assign src_ack = src_rdy && (!busy || (dst_ack && final_beat));

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state     <= IDLE;
            id_r      <= '0;
            linear_r  <= '0;
            bofs_r    <= '0;
            retire_r  <= 1'b0;
            islast_r  <= 1'b0;
            stencil_r <= 1'b0;
            sid       <= '0;
        end else if (src_ack) begin
            state     <= BUSY;
            id_r      <= i_id;
            linear_r  <= i_linear;
            bofs_r    <= i_bofs;
            retire_r  <= i_retire;
            islast_r  <= i_islast;
            stencil_r <= i_stencil;
            sid       <= beg_sel;
        end else if (busy && dst_ack) begin
            if (final_beat) state <= IDLE;
            else            sid   <= sid + ST_BW'(N_LANE);
        end
    end

    assign dst_rdy      = busy;
    assign o_id         = id_r;
    assign o_linear     = lane_addr;
    assign o_lane_valid = lane_v;
    assign o_nlane      = nlane;
    assign o_bofs       = bofs_r;
    assign o_retire     = retire_r && final_beat;
    assign o_islast     = islast_r && final_beat;

endmodule
